axi_rd_cmd_arb: RTL

- Two-requester arbiter for the single DRAM read-command port (kick/busy/addr/num handshake).
- Shares that port between requester 0 (display line prefetch, high priority) and requester 1 (general-purpose reader).
- Tracks which requester owns each outstanding read in an in-order owner FIFO, so the returning read-data stream can be steered.
- Sits between the address generators and the AXI read master.

---
 rtl/axi_rd_cmd_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axi_rd_cmd_arb.sv
// Two-requester arbiter for the DRAM read-command port, plus an in-order owner FIFO
// that steers returning read data. Optional starvation guard: define ARB_STARVE_GUARD_EN.
module axi_rd_cmd_arb #(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_kick,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_num,
  output logic        req0_busy,
  input  logic        req1_kick,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_num,
  output logic        req1_busy,
  output logic        m_kick,
  output logic [31:0] m_addr,
  output logic [31:0] m_num,
  input  logic        m_busy,
  input  logic        rd_last,
  output logic        rd_owner,
  output logic        rd_owner_valid,
  output logic        err_underflow
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE} state_e;

  state_e             state_q, state_d;
  logic               grant_q, grant_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [31:0]        m_num_q, m_num_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rd_owner_q, rd_owner_d;
  logic               rd_owner_valid_q, rd_owner_valid_d;
  logic               err_underflow_q, err_underflow_d;
  logic               fifo_mem [OUTSTANDING];

  logic push, pop, can_grant, win, starve_hit;

  assign can_grant = (state_q == S_IDLE) && (req0_kick || req1_kick) &&
                     (count_q < CNT_W'(OUTSTANDING));
  // Requester 1 wins when it is the only one asking or when the guard forces it.
  assign win = req0_kick ? starve_hit : 1'b1;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = req1_kick && (starve_cnt_q == SC_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (state_q == S_IDLE) begin
      if (!req1_kick)  starve_cnt_d = '0;
      else if (can_grant) starve_cnt_d = win ? '0 : starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict priority: the limit is only meaningful with the guard built in.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    m_addr_d = m_addr_q;
    m_num_d  = m_num_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_grant) begin
          grant_d  = win;
          m_addr_d = win ? req1_addr : req0_addr;
          m_num_d  = win ? req1_num  : req0_num;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_busy) begin
          push    = 1'b1;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: if (!m_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop             = rd_last && (count_q != '0);
    wr_ptr_d        = wr_ptr_q + PTR_W'(push);
    rd_ptr_d        = rd_ptr_q + PTR_W'(pop);
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    err_underflow_d = err_underflow_q || (rd_last && (count_q == '0));
    rd_owner_valid_d = (count_d != '0);
    // The new head may be the entry being written this very cycle.
    if (count_d == '0)                        rd_owner_d = 1'b0;
    else if (push && (rd_ptr_d == wr_ptr_q))  rd_owner_d = grant_q;
    else                                      rd_owner_d = fifo_mem[rd_ptr_d];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      grant_q          <= 1'b0;
      m_addr_q         <= '0;
      m_num_q          <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      rd_owner_q       <= 1'b0;
      rd_owner_valid_q <= 1'b0;
      err_underflow_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      m_addr_q         <= m_addr_d;
      m_num_q          <= m_num_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      rd_owner_q       <= rd_owner_d;
      rd_owner_valid_q <= rd_owner_valid_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  // NOTE: FIFO storage is not reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= grant_q;
  end

  assign m_kick         = (state_q == S_ISSUE);
  assign m_addr         = m_addr_q;
  assign m_num          = m_num_q;
  assign req0_busy      = m_busy && !grant_q && (state_q != S_IDLE);
  assign req1_busy      = m_busy &&  grant_q && (state_q != S_IDLE);
  assign rd_owner       = rd_owner_q;
  assign rd_owner_valid = rd_owner_valid_q;
  assign err_underflow  = err_underflow_q;

endmodule
